// File: rtl/scb_insert_ctrl_if.sv
// Issue-side and cell-array bus of one scoreboard bank insert controller.
// Optional statistics signals exist only when SCB_INSERT_CTRL_STAT_EN is defined.
interface scb_insert_ctrl_if #(
  parameter int N_CELL  = 8,
  parameter int W_ident = 4,
  parameter int W_pip   = 2,
  parameter int W_PA_rx = 5,
  parameter int W_state = 7
);
  logic                         iss_valid;
  logic                         iss_ready;
  logic [W_pip-1:0]             iss_pip;
  logic [W_PA_rx-1:0]           iss_rd;
  logic                         iss_cls;
  logic [N_CELL-1:0]            cell_used;
  logic [N_CELL-1:0]            cell_ck0;
  logic [N_CELL-1:0]            cell_ck1;
  logic [N_CELL-1:0]            cell_done;
  logic                         cfi_clear;
  logic [W_ident-1:0]           o_addr_insert;
  logic [W_pip-1:0]             o_pip;
  logic [W_PA_rx-1:0]           o_rd;
  logic [W_state-1:0]           o_state;
  logic                         o_clear;
  logic [$clog2(N_CELL+1)-1:0]  occ;
  logic                         wb_coll;
`ifdef SCB_INSERT_CTRL_STAT_EN
  logic [31:0]                  st_ins;
  logic [31:0]                  st_stall;

  modport master (
    output iss_valid, iss_pip, iss_rd, iss_cls, cell_used, cell_ck0, cell_ck1,
           cell_done, cfi_clear,
    input  iss_ready, o_addr_insert, o_pip, o_rd, o_state, o_clear, occ, wb_coll,
           st_ins, st_stall
  );
  modport slave (
    input  iss_valid, iss_pip, iss_rd, iss_cls, cell_used, cell_ck0, cell_ck1,
           cell_done, cfi_clear,
    output iss_ready, o_addr_insert, o_pip, o_rd, o_state, o_clear, occ, wb_coll,
           st_ins, st_stall
  );
`else
  modport master (
    output iss_valid, iss_pip, iss_rd, iss_cls, cell_used, cell_ck0, cell_ck1,
           cell_done, cfi_clear,
    input  iss_ready, o_addr_insert, o_pip, o_rd, o_state, o_clear, occ, wb_coll
  );
  modport slave (
    input  iss_valid, iss_pip, iss_rd, iss_cls, cell_used, cell_ck0, cell_ck1,
           cell_done, cfi_clear,
    output iss_ready, o_addr_insert, o_pip, o_rd, o_state, o_clear, occ, wb_coll
  );
`endif
endinterface

// File: rtl/scb_insert_ctrl.sv
// Scoreboard bank insert controller: skid-buffered issue, free-cell pick, hazard check,
// CFI clear sequencing, occupancy and write-back collision tracking.
// Define SCB_INSERT_CTRL_STAT_EN to add the st_ins / st_stall counters.
module scb_insert_ctrl #(
  parameter int N_CELL    = 8,
  parameter int W_ident   = 4,
  parameter int W_pip     = 2,
  parameter int W_PA_rx   = 5,
  parameter int W_state   = 7,
  parameter int V_FUT0    = 1,
  parameter int V_FUT1    = 4,
  parameter int FLUSH_CYC = 2
) (
  input  logic            clk,
  input  logic            rst,
  scb_insert_ctrl_if.slave bus
);
  localparam int W_OCC = $clog2(N_CELL + 1);
  localparam int W_FC  = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [W_ident-1:0] NO_INS = '1;
  localparam logic [0:0] S_RUN   = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [W_FC-1:0]     cnt_q, cnt_d;
  logic                skid_vld_q, skid_vld_d;
  logic [W_pip-1:0]    skid_pip_q, skid_pip_d;
  logic [W_PA_rx-1:0]  skid_rd_q, skid_rd_d;
  logic                skid_cls_q, skid_cls_d;
  logic [W_ident-1:0]  addr_q, addr_d;
  logic [W_pip-1:0]    pip_q, pip_d;
  logic [W_PA_rx-1:0]  rd_q, rd_d;
  logic [W_state-1:0]  st_q, st_d;
  logic                clear_q, clear_d;
  logic [W_OCC-1:0]    occ_q, occ_d;
  logic                wb_coll_q, wb_coll_d;

  logic [N_CELL-1:0]   pend_mask, free, ck_sel;
  logic [W_ident-1:0]  pick;
  logic [W_OCC-1:0]    done_cnt;
  logic [W_OCC:0]      occ_sum, occ_diff;
  logic                haz, ins_go;

  // NOTE: every signal assigned in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    pend_mask = '0;
    pick      = NO_INS;
    done_cnt  = '0;
    for (int i = 0; i < N_CELL; i++) begin
      pend_mask[i] = (addr_q == W_ident'(i));
      done_cnt     = done_cnt + W_OCC'(bus.cell_done[i]);
    end
    free = ~bus.cell_used & ~pend_mask;
    for (int i = N_CELL - 1; i >= 0; i--) begin
      if (free[i]) pick = W_ident'(i);
    end
    ck_sel = skid_cls_q ? bus.cell_ck1 : bus.cell_ck0;
    haz    = |(bus.cell_used & ~ck_sel);
    // A same-cycle clear cancels the decision, so the cell bus never sees it.
    ins_go = (state_q == S_RUN) && skid_vld_q && (free != '0) && !haz && !bus.cfi_clear;
  end

  assign bus.iss_ready = (state_q == S_RUN) && (!skid_vld_q || ins_go);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    skid_vld_d = skid_vld_q;
    skid_pip_d = skid_pip_q;
    skid_rd_d  = skid_rd_q;
    skid_cls_d = skid_cls_q;
    addr_d     = ins_go ? pick : NO_INS;
    pip_d      = pip_q;
    rd_d       = rd_q;
    st_d       = st_q;
    clear_d    = bus.cfi_clear;
    wb_coll_d  = wb_coll_q | (done_cnt > W_OCC'(1));

    if (bus.cfi_clear) begin
      state_d = S_FLUSH;
      cnt_d   = W_FC'(FLUSH_CYC - 1);
    end else if (state_q == S_FLUSH) begin
      if (cnt_q == '0) state_d = S_RUN;
      else             cnt_d   = cnt_q - 1'b1;
    end

    if (ins_go) begin
      pip_d      = skid_pip_q;
      rd_d       = skid_rd_q;
      st_d       = skid_cls_q ? W_state'(V_FUT1) : W_state'(V_FUT0);
      skid_vld_d = 1'b0;
    end
    if (bus.cfi_clear) begin
      skid_vld_d = 1'b0;
    end else if (bus.iss_valid && bus.iss_ready) begin
      skid_vld_d = 1'b1;
      skid_pip_d = bus.iss_pip;
      skid_rd_d  = bus.iss_rd;
      skid_cls_d = bus.iss_cls;
    end

    occ_sum  = {1'b0, occ_q} + (W_OCC+1)'(addr_q != NO_INS);
    occ_diff = (occ_sum < {1'b0, done_cnt}) ? '0 : occ_sum - {1'b0, done_cnt};
    if (bus.cfi_clear)                     occ_d = '0;
    else if (occ_diff > (W_OCC+1)'(N_CELL)) occ_d = W_OCC'(N_CELL);
    else                                   occ_d = occ_diff[W_OCC-1:0];
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_RUN;
      cnt_q      <= '0;
      skid_vld_q <= 1'b0;
      skid_pip_q <= '0;
      skid_rd_q  <= '0;
      skid_cls_q <= 1'b0;
      addr_q     <= NO_INS;
      pip_q      <= '0;
      rd_q       <= '0;
      st_q       <= '0;
      clear_q    <= 1'b0;
      occ_q      <= '0;
      wb_coll_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      skid_vld_q <= skid_vld_d;
      skid_pip_q <= skid_pip_d;
      skid_rd_q  <= skid_rd_d;
      skid_cls_q <= skid_cls_d;
      addr_q     <= addr_d;
      pip_q      <= pip_d;
      rd_q       <= rd_d;
      st_q       <= st_d;
      clear_q    <= clear_d;
      occ_q      <= occ_d;
      wb_coll_q  <= wb_coll_d;
    end
  end

  assign bus.o_addr_insert = addr_q;
  assign bus.o_pip         = pip_q;
  assign bus.o_rd          = rd_q;
  assign bus.o_state       = st_q;
  assign bus.o_clear       = clear_q;
  assign bus.occ           = occ_q;
  assign bus.wb_coll       = wb_coll_q;

`ifdef SCB_INSERT_CTRL_STAT_EN
  logic [31:0] st_ins_q, st_stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_ins_q   <= '0;
      st_stall_q <= '0;
    end else begin
      if (ins_go)                 st_ins_q   <= st_ins_q + 32'd1;
      if (skid_vld_q && !ins_go)  st_stall_q <= st_stall_q + 32'd1;
    end
  end

  assign bus.st_ins   = st_ins_q;
  assign bus.st_stall = st_stall_q;
`endif
endmodule
